pram_boot_loader: RTL and testbench

Sequencer that initialises the program RAM from external memory after reset. It drives the memory controller's PRAM-initialization inputs (`ld_on_rst`, `addr_counter`, `r_pram_addr`). While `ld_on_rst` is high, the memory controller owns the bus for a continuous read stream, holds fetch stalled, and writes every returned word into PRAM. When the copy completes or times out, the loader releases the core and reports status.

---
 rtl/pram_boot_loader_pkg.sv | 15 +
 rtl/pram_boot_loader_if.sv | 27 ++
 rtl/pram_boot_loader.sv | 110 +++++++++++
 tb/tb_pram_boot_loader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pram_boot_loader_pkg.sv
// Shared constants for the PRAM boot loader: FSM encoding, address width and
// per-word address step, common with mem_controller and bus_if.
package pram_boot_loader_pkg;

    localparam int ADDR_W = 16;
    localparam int IDX_W  = 14;

    localparam logic [ADDR_W-1:0] ADDR_STEP = 16'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/pram_boot_loader_if.sv
// Link between the boot loader and the memory controller's PRAM-init inputs.
// Handshake: ld_on_rst is the loader's request and stays high for the whole
// copy; bus_ack is a one-cycle per-word acknowledge, only meaningful while
// ld_on_rst is high, and the addresses advance on the cycle after it.
interface pram_boot_loader_if;
    import pram_boot_loader_pkg::*;

    logic              ld_on_rst;
    logic [ADDR_W-1:0] addr_counter;
    logic [ADDR_W-1:0] r_pram_addr;
    logic              bus_ack;

    modport master (
        output ld_on_rst,
        output addr_counter,
        output r_pram_addr,
        input  bus_ack
    );

    modport slave (
        input  ld_on_rst,
        input  addr_counter,
        input  r_pram_addr,
        output bus_ack
    );

endinterface

// File: rtl/pram_boot_loader.sv
// Copies WORDS words from external memory into PRAM after reset, with a
// per-word ack timeout; reports completion or abort as level flags.
module pram_boot_loader
    import pram_boot_loader_pkg::*;
#(
    parameter int                WORDS     = 1024,
    parameter logic [ADDR_W-1:0] EXT_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0] PRAM_BASE = 16'h0000,
    parameter int                TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    pram_boot_loader_if.master     bus,
    input  logic                   boot_req,
    output logic                   boot_done,
    output logic                   boot_err,
    output logic [IDX_W-1:0]       word_idx,
    output logic [1:0]             dbg_state
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(WORDS - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] ext_q, ext_d;
    logic [ADDR_W-1:0] pram_q, pram_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ld_q, ld_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ext_d   = ext_q;
        pram_d  = pram_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                if (bus.bus_ack) begin
                    idx_d  = idx_q + 1'b1;
                    wait_d = '0;
                    // The last ack leaves the addresses on the final word.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        ext_d  = ext_q + ADDR_STEP;
                        pram_d = pram_q + ADDR_STEP;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (TIMEOUT != 0 && wait_d == TIMEOUT_CNT) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                if (boot_req) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    ext_d   = EXT_BASE;
                    pram_d  = PRAM_BASE;
                    wait_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered copies of the next state.
    always_comb begin
        ld_d   = (state_d == ST_LOAD);
        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ext_q   <= EXT_BASE;
            pram_q  <= PRAM_BASE;
            wait_q  <= '0;
            ld_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ext_q   <= ext_d;
            pram_q  <= pram_d;
            wait_q  <= wait_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ld_on_rst    = ld_q;
    assign bus.addr_counter = ext_q;
    assign bus.r_pram_addr  = pram_q;
    assign boot_done        = done_q;
    assign boot_err         = err_q;
    assign word_idx         = idx_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_pram_boot_loader.sv
// Bench for pram_boot_loader: two instances (plain bases with a timeout, and a
// wrapping external base with the timeout disabled) against an index-level model.
module tb_pram_boot_loader;
  import pram_boot_loader_pkg::*;

  localparam int          W0 = 4;
  localparam logic [15:0] EB0 = 16'h0000;
  localparam logic [15:0] PB0 = 16'h0000;
  localparam int          T0 = 5;
  localparam int          W1 = 3;
  localparam logic [15:0] EB1 = 16'hFFFC;
  localparam logic [15:0] PB1 = 16'h0100;
  localparam int          T1 = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot_req = 1'b0;
  always #5 clk = ~clk;

  int p_words[2] = '{W0, W1};
  int p_to[2]    = '{T0, T1};
  logic [15:0] p_eb[2] = '{EB0, EB1};
  logic [15:0] p_pb[2] = '{PB0, PB1};

  pram_boot_loader_if if0 ();
  pram_boot_loader_if if1 ();

  logic        ack[2];
  logic        done_w[2], err_w[2], ld_w[2];
  logic [13:0] idx_w[2];
  logic [1:0]  st_w[2];
  logic [15:0] ea_w[2], pa_w[2];

  assign if0.bus_ack = ack[0];
  assign if1.bus_ack = ack[1];
  assign ld_w[0] = if0.ld_on_rst;
  assign ld_w[1] = if1.ld_on_rst;
  assign ea_w[0] = if0.addr_counter;
  assign ea_w[1] = if1.addr_counter;
  assign pa_w[0] = if0.r_pram_addr;
  assign pa_w[1] = if1.r_pram_addr;

  pram_boot_loader #(.WORDS(W0), .EXT_BASE(EB0), .PRAM_BASE(PB0), .TIMEOUT(T0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0), .boot_req(boot_req),
    .boot_done(done_w[0]), .boot_err(err_w[0]), .word_idx(idx_w[0]), .dbg_state(st_w[0])
  );

  pram_boot_loader #(.WORDS(W1), .EXT_BASE(EB1), .PRAM_BASE(PB1), .TIMEOUT(T1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .boot_req(boot_req),
    .boot_done(done_w[1]), .boot_err(err_w[1]), .word_idx(idx_w[1]), .dbg_state(st_w[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural model: phase 0 idle, 1 load, 2 done, 3 err
  int m_phase[2], m_idx[2], m_wt[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_idx[i]   = 0;
      m_wt[i]    = 0;
    end
  endtask

  task automatic model_step(input int i, input logic a, input logic r);
    case (m_phase[i])
      0: m_phase[i] = 1;
      1: begin
        if (a) begin
          m_wt[i] = 0;
          if (m_idx[i] == p_words[i] - 1) m_phase[i] = 2;
          m_idx[i]++;
        end else begin
          m_wt[i]++;
          if (p_to[i] != 0 && m_wt[i] >= p_to[i]) m_phase[i] = 3;
        end
      end
      default: if (r) begin
        m_phase[i] = 1;
        m_idx[i]   = 0;
        m_wt[i]    = 0;
      end
    endcase
  endtask

  // Address of the word in hand: the last word once done, else the index.
  function automatic logic [15:0] exp_addr(input logic [15:0] base, input int i);
    int cur;
    cur = (m_phase[i] == 2) ? p_words[i] - 1 : m_idx[i];
    return base + 16'(4 * cur);
  endfunction

  function automatic logic [31:0] ext_word(input logic [15:0] a);
    return {a, a ^ 16'hA5C3};
  endfunction

  // PRAM image seen by a memory controller obeying ld_on_rst
  logic [31:0] pram0[logic [15:0]];
  logic [31:0] pram1[logic [15:0]];

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        if (ld_w[0]) pram0[pa_w[0]] = ack[0] ? ext_word(ea_w[0]) : $urandom;
        if (ld_w[1]) pram1[pa_w[1]] = ack[1] ? ext_word(ea_w[1]) : $urandom;
        for (int i = 0; i < 2; i++) model_step(i, ack[i], boot_req);
      end
    end
  end

  // scoreboard: every negedge, every output of both instances
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("u%0d ld_on_rst", i), 32'(ld_w[i]), 32'(m_phase[i] == 1));
        check($sformatf("u%0d boot_done", i), 32'(done_w[i]), 32'(m_phase[i] == 2));
        check($sformatf("u%0d boot_err", i), 32'(err_w[i]), 32'(m_phase[i] == 3));
        check($sformatf("u%0d state", i), 32'(st_w[i]), 32'(m_phase[i]));
        check($sformatf("u%0d word_idx", i), 32'(idx_w[i]), 32'(m_idx[i] % 16384));
        check($sformatf("u%0d addr_counter", i), 32'(ea_w[i]), 32'(exp_addr(p_eb[i], i)));
        check($sformatf("u%0d r_pram_addr", i), 32'(pa_w[i]), 32'(exp_addr(p_pb[i], i)));
        check($sformatf("u%0d done_err_excl", i), 32'(done_w[i] & err_w[i]), 32'd0);
      end
    end
  end

  // driver: ack modes 0 random, 1 always, 2 never, 3 every 3rd, 4 every 5th,
  // 5 a fixed number of acks while loading
  int mode[2];
  int cnt[2];
  int left[2];

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      cnt[i]++;
      case (mode[i])
        0: ack[i] = 1'($urandom_range(0, 1));
        1: ack[i] = 1'b1;
        2: ack[i] = 1'b0;
        3: ack[i] = (cnt[i] % 3 == 2);
        4: ack[i] = (cnt[i] % 5 == 4);
        default: begin
          ack[i] = (m_phase[i] == 1 && left[i] > 0);
          if (ack[i]) left[i]--;
        end
      endcase
    end
  endtask

  task automatic pulse_req();
    step();
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
  endtask

  task automatic wait_both_done(input string name);
    int n;
    n = 0;
    while (!(done_w[0] && done_w[1]) && n < 80) begin
      step();
      n++;
    end
    check({name, " both_done"}, 32'(done_w[0] && done_w[1]), 32'd1);
  endtask

  task automatic check_pram(input int i);
    logic [15:0] ap;
    logic [31:0] got;
    for (int k = 0; k < p_words[i]; k++) begin
      ap = p_pb[i] + 16'(4 * k);
      if (i == 0) got = pram0.exists(ap) ? pram0[ap] : 32'hDEAD_BEEF;
      else        got = pram1.exists(ap) ? pram1[ap] : 32'hDEAD_BEEF;
      check($sformatf("u%0d pram[%0d]", i, k), got, ext_word(p_eb[i] + 16'(4 * k)));
    end
  endtask

  logic [15:0] q0[$];
  logic [15:0] q1e[$];
  logic [15:0] q1p[$];

  initial begin
    int n;
    logic seen_err;
    ack[0] = 1'b0;
    ack[1] = 1'b0;
    cnt = '{0, 0};
    left = '{0, 0};
    mode = '{1, 3};

    // reset values
    repeat (3) step();
    check("rst ld0", 32'(ld_w[0]), 32'd0);
    check("rst idx0", 32'(idx_w[0]), 32'd0);
    check("rst addr1", 32'(ea_w[1]), 32'hFFFC);
    check("rst pram1", 32'(pa_w[1]), 32'h0100);
    rst = 1'b0;

    // first boot: u0 acks every cycle, u1 every third cycle with a wrapping base
    n = 0;
    while (!(done_w[0] && done_w[1]) && n < 40) begin
      step();
      n++;
      if (ld_w[0]) q0.push_back(ea_w[0]);
      if (ld_w[1] && (q1e.size() == 0 || q1e[$] != ea_w[1])) begin
        q1e.push_back(ea_w[1]);
        q1p.push_back(pa_w[1]);
      end
    end
    check("boot1 u0 ld_cycles", 32'(q0.size()), 32'd4);
    for (int k = 0; k < q0.size() && k < 4; k++)
      check($sformatf("boot1 u0 addr%0d", k), 32'(q0[k]), 32'(4 * k));
    check("boot1 u0 done", 32'(done_w[0]), 32'd1);
    check("boot1 u0 word_idx", 32'(idx_w[0]), 32'd4);
    check("boot1 u1 addr_steps", 32'(q1e.size()), 32'd3);
    if (q1e.size() == 3) begin
      check("boot1 u1 ext0", 32'(q1e[0]), 32'hFFFC);
      check("boot1 u1 ext1", 32'(q1e[1]), 32'h0000);
      check("boot1 u1 ext2", 32'(q1e[2]), 32'h0004);
      check("boot1 u1 pram2", 32'(q1p[2]), 32'h0108);
    end
    check_pram(0);
    check_pram(1);

    // timeout: u0 gets two acks then none; u1 never acks with timeout disabled
    mode = '{5, 2};
    left[0] = 2;
    pulse_req();
    n = 0;
    while (idx_w[0] != 14'd2 && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (!err_w[0] && n < 20) begin
      step();
      n++;
    end
    check("tmo cycles_after_ack", 32'(n), 32'd5);
    check("tmo word_idx", 32'(idx_w[0]), 32'd2);
    check("tmo addr_counter", 32'(ea_w[0]), 32'd8);
    check("tmo ld_on_rst", 32'(ld_w[0]), 32'd0);
    repeat (20) step();
    check("no_tmo u1 still_loading", 32'(ld_w[1]), 32'd1);

    // ack lands exactly on the timeout cycle; u1 sees boot_req mid-load
    mode = '{4, 2};
    pulse_req();
    mode[1] = 1;
    seen_err = 1'b0;
    n = 0;
    while (!done_w[0] && n < 60) begin
      step();
      n++;
      if (err_w[0]) seen_err = 1'b1;
    end
    check("edge_ack u0 done", 32'(done_w[0]), 32'd1);
    check("edge_ack u0 no_err", 32'(seen_err), 32'd0);
    wait_both_done("edge_ack");

    // asynchronous reset while copying word 2
    mode = '{3, 3};
    pulse_req();
    n = 0;
    while (idx_w[0] != 14'd2 && n < 20) begin
      step();
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst ld0", 32'(ld_w[0]), 32'd0);
    check("arst idx0", 32'(idx_w[0]), 32'd0);
    check("arst addr0", 32'(ea_w[0]), 32'd0);
    check("arst addr1", 32'(ea_w[1]), 32'hFFFC);
    step();
    step();
    rst = 1'b0;
    mode = '{1, 1};
    wait_both_done("arst");
    check_pram(0);
    check_pram(1);

    // randomized traffic with stray boot requests
    for (int blk = 0; blk < 8; blk++) begin
      mode[0] = $urandom_range(0, 4);
      mode[1] = $urandom_range(0, 4);
      for (int c = 0; c < 50; c++) begin
        step();
        boot_req = ($urandom_range(0, 5) == 0);
      end
    end
    boot_req = 1'b0;
    mode = '{1, 1};
    pulse_req();
    wait_both_done("rand");
    check_pram(0);
    check_pram(1);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
